// File: rtl/mdio_slave_bridge.sv
// Clause-22 MDIO slave: decodes management frames from the station manager and
// performs the matching read or write on the register block's local bus.
module mdio_slave_bridge #(
    parameter int PREAMBLE_MIN = 32,
    parameter int BUS_TIMEOUT  = 255
) (
    input  logic        w_ARstLogic_L,
    input  logic        i_Clk,
    input  logic        i_Mdc,
    input  logic        i_MdioIn,
    output logic        o_MdioOut,
    output logic        o_MdioOe,
    input  logic [4:0]  i5_PhyAddr,
    output logic        o_Cyc,
    output logic        o_Stb,
    output logic        o_WEn,
    output logic [7:0]  o8_Addr,
    output logic [31:0] o32_WrData,
    input  logic [31:0] i32_RdData,
    input  logic        i_Ack,
    input  logic        i_Stall,
    output logic        o_FrameErr
);

    localparam logic [3:0] S_HUNT    = 4'd0;
    localparam logic [3:0] S_ST      = 4'd1;
    localparam logic [3:0] S_OP      = 4'd2;
    localparam logic [3:0] S_ADR     = 4'd3;
    localparam logic [3:0] S_SKIP    = 4'd4;
    localparam logic [3:0] S_TA_RD   = 4'd5;
    localparam logic [3:0] S_DATA_RD = 4'd6;
    localparam logic [3:0] S_TA_WR   = 4'd7;
    localparam logic [3:0] S_DATA_WR = 4'd8;

    localparam logic [7:0] PRE_MIN = 8'(PREAMBLE_MIN);
    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    logic        mdc_meta_q, mdc_sync_q, mdc_prev_q;
    logic        mdio_meta_q, mdio_sync_q;
    logic        mdc_rise;
    logic        bit_in;

    logic [3:0]  state_q, state_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        op_hi_q, op_hi_d;
    logic        op_rd_q, op_rd_d;
    logic [8:0]  adr_sr_q, adr_sr_d;
    logic [15:0] sr_q, sr_d;
    logic [15:0] rd_val_q, rd_val_d;
    logic        cyc_q, cyc_d;
    logic        wen_q, wen_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        oe_q, oe_d;
    logic        out_q, out_d;
    logic        err_q, err_d;

    // Stall only holds the request, which the ack-driven handshake already does.
    logic        unused_bits;
    assign unused_bits = ^{i_Stall, i32_RdData[31:16]};

    assign mdc_rise = mdc_sync_q & ~mdc_prev_q;
    assign bit_in   = mdio_sync_q;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        bit_cnt_d = bit_cnt_q;
        op_hi_d   = op_hi_q;
        op_rd_d   = op_rd_q;
        adr_sr_d  = adr_sr_q;
        sr_d      = sr_q;
        rd_val_d  = rd_val_q;
        cyc_d     = cyc_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        to_cnt_d  = to_cnt_q;
        oe_d      = oe_q;
        out_d     = out_q;
        err_d     = 1'b0;

        if (cyc_q) begin
            if (i_Ack) begin
                cyc_d = 1'b0;
                if (!wen_q) rd_val_d = i32_RdData[15:0];
            end else if (to_cnt_q == TO_LAST) begin
                cyc_d = 1'b0;
                err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
        end

        // Frame decode runs once per MDC bit; bus issue below overrides the handshake.
        if (mdc_rise) begin
            case (state_q)
                S_HUNT: begin
                    if (bit_in) begin
                        if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + 8'd1;
                    end else if (pre_cnt_q >= PRE_MIN) begin
                        state_d   = S_ST;
                        pre_cnt_d = 8'd0;
                    end else begin
                        pre_cnt_d = 8'd0;
                    end
                end
                S_ST: begin
                    bit_cnt_d = 5'd0;
                    if (bit_in) begin
                        state_d = S_OP;
                    end else begin
                        state_d = S_HUNT;
                        err_d   = 1'b1;
                    end
                end
                S_OP: begin
                    if (bit_cnt_q == 5'd0) begin
                        op_hi_d   = bit_in;
                        bit_cnt_d = 5'd1;
                    end else if (op_hi_q != bit_in) begin
                        op_rd_d   = op_hi_q;
                        bit_cnt_d = 5'd0;
                        state_d   = S_ADR;
                    end else begin
                        state_d = S_HUNT;
                        err_d   = 1'b1;
                    end
                end
                S_ADR: begin
                    adr_sr_d = {adr_sr_q[7:0], bit_in};
                    if (bit_cnt_q == 5'd9) begin
                        bit_cnt_d = 5'd0;
                        if (adr_sr_q[8:4] != i5_PhyAddr) begin
                            state_d = S_SKIP;
                        end else begin
                            addr_d = {1'b0, adr_sr_q[3:0], bit_in, 2'b00};
                            if (op_rd_q) begin
                                state_d  = S_TA_RD;
                                cyc_d    = 1'b1;
                                wen_d    = 1'b0;
                                to_cnt_d = 8'd0;
                                rd_val_d = 16'hFFFF;
                            end else begin
                                state_d = S_TA_WR;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_SKIP: begin
                    if (bit_cnt_q == 5'd17) begin
                        state_d   = S_HUNT;
                        pre_cnt_d = 8'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_TA_RD: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        oe_d      = 1'b1;
                        out_d     = 1'b0;
                        bit_cnt_d = 5'd0;
                        state_d   = S_DATA_RD;
                        if (cyc_q && i_Ack) begin
                            sr_d = i32_RdData[15:0];
                        end else if (cyc_q) begin
                            // Slave too slow: return all-ones and abandon the read.
                            sr_d  = 16'hFFFF;
                            cyc_d = 1'b0;
                            err_d = 1'b1;
                        end else begin
                            sr_d = rd_val_q;
                        end
                    end
                end
                S_DATA_RD: begin
                    if (bit_cnt_q == 5'd16) begin
                        oe_d      = 1'b0;
                        out_d     = 1'b1;
                        state_d   = S_HUNT;
                        pre_cnt_d = 8'd0;
                    end else begin
                        out_d     = sr_q[15];
                        sr_d      = {sr_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_TA_WR: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = 5'd0;
                        state_d   = S_DATA_WR;
                    end
                end
                S_DATA_WR: begin
                    sr_d = {sr_q[14:0], bit_in};
                    if (bit_cnt_q == 5'd15) begin
                        wdata_d   = {sr_q[14:0], bit_in};
                        cyc_d     = 1'b1;
                        wen_d     = 1'b1;
                        to_cnt_d  = 8'd0;
                        state_d   = S_HUNT;
                        pre_cnt_d = 8'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d   = S_HUNT;
                    pre_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge w_ARstLogic_L) begin
        if (!w_ARstLogic_L) begin
            mdc_meta_q  <= 1'b0;
            mdc_sync_q  <= 1'b0;
            mdc_prev_q  <= 1'b0;
            mdio_meta_q <= 1'b1;
            mdio_sync_q <= 1'b1;
            state_q     <= S_HUNT;
            pre_cnt_q   <= 8'd0;
            bit_cnt_q   <= 5'd0;
            op_hi_q     <= 1'b0;
            op_rd_q     <= 1'b0;
            adr_sr_q    <= 9'd0;
            sr_q        <= 16'hFFFF;
            rd_val_q    <= 16'hFFFF;
            cyc_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 16'd0;
            to_cnt_q    <= 8'd0;
            oe_q        <= 1'b0;
            out_q       <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            mdc_meta_q  <= i_Mdc;
            mdc_sync_q  <= mdc_meta_q;
            mdc_prev_q  <= mdc_sync_q;
            mdio_meta_q <= i_MdioIn;
            mdio_sync_q <= mdio_meta_q;
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            op_hi_q     <= op_hi_d;
            op_rd_q     <= op_rd_d;
            adr_sr_q    <= adr_sr_d;
            sr_q        <= sr_d;
            rd_val_q    <= rd_val_d;
            cyc_q       <= cyc_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            to_cnt_q    <= to_cnt_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    assign o_MdioOut  = out_q;
    assign o_MdioOe   = oe_q;
    assign o_Cyc      = cyc_q;
    assign o_Stb      = cyc_q;
    assign o_WEn      = wen_q;
    assign o8_Addr    = addr_q;
    assign o32_WrData = {16'h0000, wdata_q};
    assign o_FrameErr = err_q;

endmodule
